lsu: RTL and testbench

- Parametrised load/store unit that replaces the core's inline read-modify-write memory path.
- Accepts one load or store request at a time from the execute stage and drives a byte-enabled data bus with a valid/ready handshake.
- Returns sign- or zero-extended load data, or a precise exception (misaligned, access fault, bus timeout, illegal size) with the faulting address for mtval.

---
 rtl/lsu.sv | 171 +++++++++++++++++
 tb/tb_lsu.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: one request at a time, byte-enabled valid/ready bus, extended load data
// and precise exceptions (cause + mtval address) returned as a one-cycle response pulse.
//   state | meaning
//   IDLE  | ready for a request; decodes illegal/misaligned before any bus access
//   BUS   | bus request outstanding; waits for ready, error or timeout
//   RESP  | rsp_valid_o pulse; rsp_* registers hold the result
module lsu #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_f3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic [XLEN-1:0]   mem_rdata_i,
    input  logic              mem_err_i,
    output logic              rsp_valid_o,
    output logic [4:0]        rsp_rd_o,
    output logic [XLEN-1:0]   rsp_rdata_o,
    output logic              rsp_exc_o,
    output logic [3:0]        rsp_cause_o,
    output logic [ADDR_W-1:0] rsp_addr_o
);
    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t state, state_nx;

    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [4:0]        rd_q;
    logic [TO_W-1:0]   to_cnt;

    logic              illegal, misaligned, early_exc, timeout_hit;
    logic [BE_W-1:0]   be_base;
    logic [OFF_W-1:0]  off_in;
    logic [XLEN-1:0]   rd_shift, ld_data;

    always_comb begin
        off_in  = req_addr_i[OFF_W-1:0];
        illegal = (req_f3_i == 3'd7) || (req_we_i && req_f3_i[2]) ||
                  ((XLEN == 32) && (req_f3_i == 3'd3 || req_f3_i == 3'd6));
        case (req_f3_i[1:0])
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr_i[0];
            2'd2:    misaligned = |req_addr_i[1:0];
            default: misaligned = |req_addr_i[2:0];
        endcase
        early_exc = illegal || misaligned;
        case (req_f3_i[1:0])
            2'd0:    be_base = BE_W'(1);
            2'd1:    be_base = BE_W'(3);
            2'd2:    be_base = BE_W'(15);
            default: be_base = '1;
        endcase
    end

    always_comb begin
        rd_shift = mem_rdata_i >> {addr_q[OFF_W-1:0], 3'b000};
        case (f3_q[1:0])
            2'd0:    ld_data = f3_q[2] ? XLEN'(rd_shift[7:0])  : XLEN'($signed(rd_shift[7:0]));
            2'd1:    ld_data = f3_q[2] ? XLEN'(rd_shift[15:0]) : XLEN'($signed(rd_shift[15:0]));
            2'd2:    ld_data = f3_q[2] ? XLEN'(rd_shift[31:0]) : XLEN'($signed(rd_shift[31:0]));
            default: ld_data = rd_shift;
        endcase
    end

    // A ready arriving in the last allowed cycle wins over the timeout.
    assign timeout_hit = (TIMEOUT != 0) && (state == BUS) && !mem_ready_i &&
                         (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        req_ready_o = 1'b0;
        mem_valid_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_nx = early_exc ? RESP : BUS;
            end
            BUS: begin
                mem_valid_o = 1'b1;
                if (mem_ready_i || timeout_hit) state_nx = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q        <= 1'b0;
            f3_q        <= '0;
            addr_q      <= '0;
            rd_q        <= '0;
            to_cnt      <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= '0;
            mem_wdata_o <= '0;
            rsp_rd_o    <= '0;
            rsp_rdata_o <= '0;
            rsp_exc_o   <= 1'b0;
            rsp_cause_o <= '0;
            rsp_addr_o  <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid_i) begin
                    we_q        <= req_we_i;
                    f3_q        <= req_f3_i;
                    addr_q      <= req_addr_i;
                    rd_q        <= req_rd_i;
                    to_cnt      <= '0;
                    mem_we_o    <= req_we_i;
                    mem_addr_o  <= {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    mem_be_o    <= be_base << off_in;
                    mem_wdata_o <= req_wdata_i << {off_in, 3'b000};
                    if (early_exc) begin
                        rsp_rd_o    <= req_we_i ? 5'd0 : req_rd_i;
                        rsp_rdata_o <= '0;
                        rsp_exc_o   <= 1'b1;
                        rsp_cause_o <= illegal ? 4'd2 : (req_we_i ? 4'd6 : 4'd4);
                        rsp_addr_o  <= req_addr_i;
                    end
                end
                BUS: begin
                    if (mem_ready_i || timeout_hit) begin
                        rsp_rd_o   <= we_q ? 5'd0 : rd_q;
                        rsp_addr_o <= addr_q;
                        if (timeout_hit || mem_err_i) begin
                            rsp_rdata_o <= '0;
                            rsp_exc_o   <= 1'b1;
                            rsp_cause_o <= we_q ? 4'd7 : 4'd5;
                        end else begin
                            rsp_rdata_o <= we_q ? '0 : ld_data;
                            rsp_exc_o   <= 1'b0;
                            rsp_cause_o <= 4'd0;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: a 32-bit unit (TIMEOUT=16) and a 64-bit unit (TIMEOUT=4) share stimulus;
// responses are compared with an arithmetic reference model of the load/store rules.
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    bit          sel = 1'b0;

    logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_f3 = '0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        mem_ready_a = 1'b0, mem_ready_b = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        mem_err = 1'b0;

    logic        a_req_ready, a_mem_valid, a_mem_we, a_rsp_valid, a_rsp_exc;
    logic [31:0] a_mem_addr, a_mem_wdata, a_rsp_rdata, a_rsp_addr;
    logic [3:0]  a_mem_be, a_rsp_cause;
    logic [4:0]  a_rsp_rd;
    logic        b_req_ready, b_mem_valid, b_mem_we, b_rsp_valid, b_rsp_exc;
    logic [31:0] b_mem_addr, b_rsp_addr;
    logic [63:0] b_mem_wdata, b_rsp_rdata;
    logic [7:0]  b_mem_be;
    logic [3:0]  b_rsp_cause;
    logic [4:0]  b_rsp_rd;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(16)) u_a (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_a), .req_ready_o(a_req_ready), .req_we_i(req_we),
        .req_f3_i(req_f3), .req_addr_i(req_addr), .req_wdata_i(req_wdata[31:0]), .req_rd_i(req_rd),
        .mem_valid_o(a_mem_valid), .mem_ready_i(mem_ready_a), .mem_we_o(a_mem_we),
        .mem_addr_o(a_mem_addr), .mem_be_o(a_mem_be), .mem_wdata_o(a_mem_wdata),
        .mem_rdata_i(mem_rdata[31:0]), .mem_err_i(mem_err),
        .rsp_valid_o(a_rsp_valid), .rsp_rd_o(a_rsp_rd), .rsp_rdata_o(a_rsp_rdata),
        .rsp_exc_o(a_rsp_exc), .rsp_cause_o(a_rsp_cause), .rsp_addr_o(a_rsp_addr)
    );

    lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(4)) u_b (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_b), .req_ready_o(b_req_ready), .req_we_i(req_we),
        .req_f3_i(req_f3), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_rd_i(req_rd),
        .mem_valid_o(b_mem_valid), .mem_ready_i(mem_ready_b), .mem_we_o(b_mem_we),
        .mem_addr_o(b_mem_addr), .mem_be_o(b_mem_be), .mem_wdata_o(b_mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
        .rsp_valid_o(b_rsp_valid), .rsp_rd_o(b_rsp_rd), .rsp_rdata_o(b_rsp_rdata),
        .rsp_exc_o(b_rsp_exc), .rsp_cause_o(b_rsp_cause), .rsp_addr_o(b_rsp_addr)
    );

    logic        o_req_ready, o_mem_valid, o_mem_we, o_rsp_valid, o_rsp_exc;
    logic [31:0] o_mem_addr, o_rsp_addr;
    logic [63:0] o_mem_wdata, o_rsp_rdata, o_mem_be;
    logic [3:0]  o_rsp_cause;
    logic [4:0]  o_rsp_rd;

    always_comb begin
        o_req_ready = sel ? b_req_ready : a_req_ready;
        o_mem_valid = sel ? b_mem_valid : a_mem_valid;
        o_mem_we    = sel ? b_mem_we    : a_mem_we;
        o_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
        o_mem_be    = sel ? {56'd0, b_mem_be} : {60'd0, a_mem_be};
        o_mem_wdata = sel ? b_mem_wdata : {32'd0, a_mem_wdata};
        o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
        o_rsp_rd    = sel ? b_rsp_rd    : a_rsp_rd;
        o_rsp_rdata = sel ? b_rsp_rdata : {32'd0, a_rsp_rdata};
        o_rsp_exc   = sel ? b_rsp_exc   : a_rsp_exc;
        o_rsp_cause = sel ? b_rsp_cause : a_rsp_cause;
        o_rsp_addr  = sel ? b_rsp_addr  : a_rsp_addr;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (unit %0d, t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    // Reference model: expected response and bus fields from the load/store rules.
    task automatic model(input bit s, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rdata, input bit err,
                         input int waits, output int lat, output int nbus, output bit exc,
                         output logic [3:0] cause, output logic [63:0] ldata,
                         output logic [63:0] be, output logic [63:0] wsh, output logic [31:0] baddr);
        int xlen = s ? 64 : 32;
        int to   = s ? 4 : 16;
        int nb   = 1 << f3[1:0];
        int off  = int'(addr % (xlen / 8));
        logic [63:0] xm = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        logic [63:0] m  = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        bit illegal = (f3 == 3'd7) || (we && f3[2]) || (xlen == 32 && (f3 == 3'd3 || f3 == 3'd6));
        be    = ((64'd1 << nb) - 64'd1) << off;
        wsh   = ((wdata & xm) << (8 * off)) & xm;
        baddr = addr - 32'(off);
        ldata = ((rdata & xm) >> (8 * off)) & m;
        if (!f3[2] && nb < 8 && ldata[8 * nb - 1]) ldata = ldata | ~m;
        ldata = ldata & xm;
        if (illegal) begin
            exc = 1; cause = 4'd2; lat = 1; nbus = 0;
        end else if (addr % nb != 0) begin
            exc = 1; cause = we ? 4'd6 : 4'd4; lat = 1; nbus = 0;
        end else if (to != 0 && waits >= to) begin
            exc = 1; cause = we ? 4'd7 : 4'd5; lat = to + 1; nbus = to;
        end else begin
            exc = err; cause = err ? (we ? 4'd7 : 4'd5) : 4'd0; lat = waits + 2; nbus = waits + 1;
        end
        if (exc || we) ldata = '0;
    endtask

    task automatic run_txn(input bit s, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [63:0] wdata, input logic [4:0] rd, input logic [63:0] rdata,
                           input bit err, input int waits);
        int lat, nbus, c, bus;
        bit exc, done;
        logic [3:0] cause;
        logic [63:0] ldata, be, wsh;
        logic [31:0] baddr;
        model(s, we, f3, addr, wdata, rdata, err, waits, lat, nbus, exc, cause, ldata, be, wsh, baddr);
        @(negedge clk);
        sel = s;
        req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
        req_valid_a = !s; req_valid_b = s;
        #1 check_eq("req_ready", {63'd0, o_req_ready}, 64'd1);
        @(posedge clk);
        c = 0; bus = 0; done = 0;
        while (!done && c < 60) begin
            @(negedge clk);
            c++;
            req_valid_a = 0; req_valid_b = 0;
            req_we = 1'($urandom); req_f3 = 3'($urandom); req_addr = $urandom;
            req_wdata = {$urandom, $urandom}; req_rd = 5'($urandom);
            mem_ready_a = 0; mem_ready_b = 0;
            mem_err = 1'($urandom); mem_rdata = {$urandom, $urandom};
            #1;
            if (o_mem_valid) begin
                bus++;
                check_eq("mem_addr", {32'd0, o_mem_addr}, {32'd0, baddr});
                check_eq("mem_be", o_mem_be, be);
                check_eq("mem_we", {63'd0, o_mem_we}, {63'd0, we});
                check_eq("mem_wdata", o_mem_wdata, wsh);
                if (bus == waits + 1) begin
                    mem_ready_a = !s; mem_ready_b = s;
                    mem_err = err; mem_rdata = rdata;
                end
            end
            if (o_rsp_valid) begin
                done = 1;
                check_eq("latency", 64'(c), 64'(lat));
                check_eq("bus_cycles", 64'(bus), 64'(nbus));
                check_eq("rsp_exc", {63'd0, o_rsp_exc}, {63'd0, exc});
                if (exc) check_eq("rsp_cause", {60'd0, o_rsp_cause}, {60'd0, cause});
                check_eq("rsp_rd", {59'd0, o_rsp_rd}, we ? 64'd0 : {59'd0, rd});
                check_eq("rsp_rdata", o_rsp_rdata, ldata);
                check_eq("rsp_addr", {32'd0, o_rsp_addr}, {32'd0, addr});
            end
        end
        if (!done) check_eq("rsp_wait_expired", 64'd0, 64'd1);
        @(negedge clk);
        mem_ready_a = 0; mem_ready_b = 0;
        #1;
        check_eq("rsp_one_cycle", {63'd0, o_rsp_valid}, 64'd0);
        check_eq("mem_valid_after", {63'd0, o_mem_valid}, 64'd0);
        check_eq("ready_after", {63'd0, o_req_ready}, 64'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready_a", {63'd0, a_req_ready}, 64'd1);
        check_eq("rst_ready_b", {63'd0, b_req_ready}, 64'd1);
        check_eq("rst_mem_valid", {62'd0, a_mem_valid, b_mem_valid}, 64'd0);
        check_eq("rst_rsp_valid", {62'd0, a_rsp_valid, b_rsp_valid}, 64'd0);
        check_eq("rst_be", {52'd0, a_mem_be, b_mem_be}, 64'd0);
        check_eq("rst_rdata", b_rsp_rdata | {32'd0, a_rsp_rdata}, 64'd0);
        @(negedge clk);
        rst = 0;

        // LB sign extension, SH lanes, misaligned LW/SW, LHU error after 5 waits
        run_txn(0, 0, 3'd0, 32'h103, 64'h0, 5'd7, 64'h80FF_0000, 0, 0);
        run_txn(0, 1, 3'd1, 32'h206, 64'h1234_ABCD, 5'd9, 64'h0, 0, 0);
        run_txn(0, 0, 3'd2, 32'h102, 64'h0, 5'd3, 64'h0, 0, 0);
        run_txn(0, 1, 3'd2, 32'h101, 64'h55, 5'd3, 64'h0, 0, 0);
        run_txn(0, 0, 3'd5, 32'h002, 64'h0, 5'd4, 64'hFFFF_FFFF, 1, 5);
        run_txn(0, 0, 3'd3, 32'h008, 64'h0, 5'd4, 64'h0, 0, 0);
        run_txn(0, 0, 3'd0, 32'h001, 64'h0, 5'd0, 64'h0000_7F00, 0, 3);
        // 64-bit unit: timeout, LD, LWU, f3=7, SD
        run_txn(1, 0, 3'd2, 32'h010, 64'h0, 5'd1, 64'h0, 0, 100);
        run_txn(1, 0, 3'd3, 32'h008, 64'h0, 5'd2, 64'h8123_4567_89AB_CDEF, 0, 0);
        run_txn(1, 0, 3'd6, 32'h00C, 64'h0, 5'd2, 64'hF000_0001_0000_0000, 0, 3);
        run_txn(1, 0, 3'd7, 32'h000, 64'h0, 5'd2, 64'h0, 0, 0);
        run_txn(1, 1, 3'd3, 32'h018, 64'hDEAD_BEEF_0123_4567, 5'd2, 64'h0, 0, 1);
        run_txn(1, 1, 3'd0, 32'h01B, 64'hA5, 5'd2, 64'h0, 1, 2);

        for (int i = 0; i < 150; i++) begin
            bit s, we, err;
            logic [2:0] f3;
            logic [31:0] addr;
            int waits;
            s = 1'($urandom); we = 1'($urandom); f3 = 3'($urandom);
            if (we && ($urandom % 4 != 0)) f3[2] = 1'b0;
            addr = $urandom & 32'h0000_FFFF;
            if ($urandom % 3 != 0) addr = addr & ~(32'h7);
            waits = ($urandom % 10 == 0) ? 20 : int'($urandom % 6);
            err = ($urandom % 8 == 0);
            run_txn(s, we, f3, addr, {$urandom, $urandom}, 5'($urandom), {$urandom, $urandom}, err, waits);
        end

        // reset while the 64-bit unit is waiting on the bus
        @(negedge clk);
        sel = 1;
        req_we = 0; req_f3 = 3'd2; req_addr = 32'h40; req_rd = 5'd5; req_valid_b = 1;
        @(posedge clk);
        @(negedge clk);
        req_valid_b = 0;
        #1 check_eq("mid_bus_valid", {63'd0, o_mem_valid}, 64'd1);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        check_eq("rst_drop_valid", {63'd0, o_mem_valid}, 64'd0);
        check_eq("rst_no_rsp", {63'd0, o_rsp_valid}, 64'd0);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1 check_eq("post_rst_no_rsp", {63'd0, o_rsp_valid}, 64'd0);
        end
        check_eq("post_rst_ready", {63'd0, o_req_ready}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
